// File: rtl/ddr3_rx_lane_trainer_if.sv
// Trainer <-> sequencer/IOD signal bundle for one DDR3 receive lane.
// DDR3_RX_TRAIN_DEBUG_EN adds the eye statistics outputs.
`timescale 1ns/1ps
interface ddr3_rx_lane_trainer_if;
    logic       start;
    logic [3:0] rx_data;
    logic       delay_line_out_of_range;
    logic       delay_line_move;
    logic       delay_line_direction;
    logic       delay_line_load;
    logic       rx_bit_slip;
    logic       busy;
    logic       train_done;
    logic       train_fail;
    logic [7:0] tap_center;
    logic [1:0] slip_count;
`ifdef DDR3_RX_TRAIN_DEBUG_EN
    logic [7:0] eye_first;
    logic [7:0] eye_last;
    logic [8:0] eye_width;
`else
    // Eye statistics are not carried in this build.
`endif

    modport slave (
        input  start, rx_data, delay_line_out_of_range,
        output delay_line_move, delay_line_direction, delay_line_load, rx_bit_slip,
        output busy, train_done, train_fail, tap_center, slip_count
`ifdef DDR3_RX_TRAIN_DEBUG_EN
        , output eye_first, eye_last, eye_width
`endif
    );

    modport master (
        output start, rx_data, delay_line_out_of_range,
        input  delay_line_move, delay_line_direction, delay_line_load, rx_bit_slip,
        input  busy, train_done, train_fail, tap_center, slip_count
`ifdef DDR3_RX_TRAIN_DEBUG_EN
        , input eye_first, eye_last, eye_width
`endif
    );
endinterface

// File: rtl/ddr3_rx_lane_trainer.sv
// DDR3 read-capture trainer: tap sweep, park at eye centre, bit-slip to word alignment.
// Optional eye statistics outputs under DDR3_RX_TRAIN_DEBUG_EN.
`timescale 1ns/1ps
module ddr3_rx_lane_trainer #(
    parameter logic [3:0] PATTERN       = 4'b0011,
    parameter int         MATCH_COUNT   = 16,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         MAX_TAPS      = 128
) (
    input logic                   fab_clk,
    input logic                   arst_n,
    ddr3_rx_lane_trainer_if.slave lane
);
    localparam int         CW       = $clog2(SETTLE_CYCLES + 1) + 1;
    localparam int         MW       = $clog2(MATCH_COUNT) + 1;
    localparam logic [7:0] LAST_TAP = 8'(MAX_TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_CHECK, S_STEP, S_CENTER, S_ALIGN, S_DONE, S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic            align_q, align_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [MW-1:0]   mcnt_q, mcnt_d;
    logic [3:0]      ref_q, ref_d;
    logic [7:0]      tap_q, tap_d, first_q, first_d, last_q, last_d;
    logic            seen_q, seen_d;
    logic            move_q, move_d, dir_q, dir_d, load_q, load_d, slip_q, slip_d;
    logic            busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [7:0]      center_q, center_d;
    logic [1:0]      slips_q, slips_d;
    logic [7:0]      target;
    logic            word_ok;

    function automatic logic is_rot(input logic [3:0] w);
        return (w == PATTERN) || (w == {PATTERN[2:0], PATTERN[3]}) ||
               (w == {PATTERN[1:0], PATTERN[3:2]}) || (w == {PATTERN[0], PATTERN[3:1]});
    endfunction

    assign target = first_q + ((last_q - first_q) >> 1);

    always_comb begin
        state_d  = state_q;
        align_d  = align_q;
        wait_d   = wait_q;
        mcnt_d   = mcnt_q;
        ref_d    = ref_q;
        tap_d    = tap_q;
        first_d  = first_q;
        last_d   = last_q;
        seen_d   = seen_q;
        move_d   = 1'b0;
        dir_d    = dir_q;
        load_d   = 1'b0;
        slip_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = done_q;
        fail_d   = fail_q;
        center_d = center_q;
        slips_d  = slips_q;
        word_ok  = 1'b0;
        case (state_q)
            S_IDLE: if (lane.start) begin
                done_d  = 1'b0;
                fail_d  = 1'b0;
                slips_d = 2'd0;
                busy_d  = 1'b1;
                load_d  = 1'b1;
                tap_d   = 8'd0;
                first_d = 8'd0;
                last_d  = 8'd0;
                seen_d  = 1'b0;
                align_d = 1'b0;
                wait_d  = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (wait_q == CW'(SETTLE_CYCLES - 1)) begin
                    wait_d  = '0;
                    mcnt_d  = '0;
                    state_d = align_q ? S_ALIGN : S_CHECK;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_CHECK: begin
                // First word must be some rotation; the rest must repeat it.
                word_ok = (mcnt_q == '0) ? is_rot(lane.rx_data) : (lane.rx_data == ref_q);
                if (mcnt_q == '0) ref_d = lane.rx_data;
                if (!word_ok) begin
                    state_d = seen_q ? S_CENTER : S_STEP;
                end else if (mcnt_q == MW'(MATCH_COUNT - 1)) begin
                    if (!seen_q) first_d = tap_q;
                    last_d  = tap_q;
                    seen_d  = 1'b1;
                    state_d = S_STEP;
                end else begin
                    mcnt_d = mcnt_q + 1'b1;
                end
            end
            S_STEP: begin
                if (lane.delay_line_out_of_range || tap_q == LAST_TAP) begin
                    wait_d  = '0;
                    state_d = seen_q ? S_CENTER : S_FAIL;
                end else begin
                    move_d  = 1'b1;
                    dir_d   = 1'b1;
                    tap_d   = tap_q + 8'd1;
                    state_d = S_SETTLE;
                end
            end
            S_CENTER: begin
                // The range flag is judged only once a decrement has settled, since
                // the sweep may have entered here with the upper limit still flagged.
                if (wait_q == '0) begin
                    if (tap_q > target) begin
                        move_d = 1'b1;
                        dir_d  = 1'b0;
                        tap_d  = tap_q - 8'd1;
                        wait_d = CW'(1);
                    end else begin
                        align_d = 1'b1;
                        state_d = S_SETTLE;
                    end
                end else if (wait_q == CW'(SETTLE_CYCLES)) begin
                    wait_d = '0;
                    if (lane.delay_line_out_of_range) state_d = S_FAIL;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_ALIGN: begin
                if (lane.rx_data != PATTERN) begin
                    if (slips_q == 2'd3) begin
                        state_d = S_FAIL;
                    end else begin
                        slip_d  = 1'b1;
                        slips_d = slips_q + 2'd1;
                        state_d = S_SETTLE;
                    end
                end else if (mcnt_q == MW'(MATCH_COUNT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    mcnt_d = mcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                center_d = target;
                state_d  = S_IDLE;
            end
            S_FAIL: begin
                fail_d   = 1'b1;
                busy_d   = 1'b0;
                center_d = tap_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            align_q  <= 1'b0;
            wait_q   <= '0;
            mcnt_q   <= '0;
            ref_q    <= 4'd0;
            tap_q    <= 8'd0;
            first_q  <= 8'd0;
            last_q   <= 8'd0;
            seen_q   <= 1'b0;
            move_q   <= 1'b0;
            dir_q    <= 1'b0;
            load_q   <= 1'b0;
            slip_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            center_q <= 8'd0;
            slips_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            align_q  <= align_d;
            wait_q   <= wait_d;
            mcnt_q   <= mcnt_d;
            ref_q    <= ref_d;
            tap_q    <= tap_d;
            first_q  <= first_d;
            last_q   <= last_d;
            seen_q   <= seen_d;
            move_q   <= move_d;
            dir_q    <= dir_d;
            load_q   <= load_d;
            slip_q   <= slip_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fail_q   <= fail_d;
            center_q <= center_d;
            slips_q  <= slips_d;
        end
    end

    assign lane.delay_line_move      = move_q;
    assign lane.delay_line_direction = dir_q;
    assign lane.delay_line_load      = load_q;
    assign lane.rx_bit_slip          = slip_q;
    assign lane.busy                 = busy_q;
    assign lane.train_done           = done_q;
    assign lane.train_fail           = fail_q;
    assign lane.tap_center           = center_q;
    assign lane.slip_count           = slips_q;

`ifdef DDR3_RX_TRAIN_DEBUG_EN
    logic [7:0] eye_first_q, eye_last_q;
    logic [8:0] eye_width_q;

    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            eye_first_q <= 8'd0;
            eye_last_q  <= 8'd0;
            eye_width_q <= 9'd0;
        end else if (state_q == S_DONE || state_q == S_FAIL) begin
            eye_first_q <= first_q;
            eye_last_q  <= last_q;
            eye_width_q <= seen_q ? ({1'b0, last_q} - {1'b0, first_q} + 9'd1) : 9'd0;
        end
    end

    assign lane.eye_first = eye_first_q;
    assign lane.eye_last  = eye_last_q;
    assign lane.eye_width = eye_width_q;
`else
    // Without the debug build the eye bounds stay internal.
`endif
endmodule
